// File: rtl/ysyx_24080006_pkg.sv
// Shared types and encodings for the SYSTEM-instruction unit and its CSR-file access interface.
package ysyx_24080006_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_TRAP,
        S_WB,
        S_REDIR
    } sysu_state_e;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_NONE     = 12'h000,
        CSR_MSTATUS  = 12'h300,
        CSR_MTVEC    = 12'h305,
        CSR_MSCRATCH = 12'h340,
        CSR_MEPC     = 12'h341,
        CSR_MCAUSE   = 12'h342
    } system_e;

    typedef struct packed {
        logic    csr_enable;
        csr_op_e csr_op;
        system_e csr_name;
    } csr_set_t;

    typedef enum logic [1:0] {
        OP_CSR,
        OP_ECALL,
        OP_MRET
    } op_kind_e;

    localparam logic [2:0]  F3_PRIV    = 3'b000;
    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;
    localparam logic [11:0] F12_MRET   = 12'h302;

    // Set/clear with a zero source register or zimm degrade to a pure read.
    function automatic csr_op_e csr_op_of(input logic [1:0] f3_lo, input logic [4:0] src);
        case (f3_lo)
            2'b01:   return CSR_WRITE;
            2'b10:   return (src == 5'd0) ? CSR_READ : CSR_SET;
            2'b11:   return (src == 5'd0) ? CSR_READ : CSR_CLEAR;
            default: return CSR_READ;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24080006_sysu.sv
// SYSTEM-instruction execution unit: sequences CSR accesses, ecall/mret commits, rd writeback
// and fetch redirects as a single five-state FSM.
module ysyx_24080006_sysu
    import ysyx_24080006_pkg::*;
#(
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [31:0] TARGET_MASK = 32'hFFFF_FFFE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [11:0] in_imm12,
    input  logic [4:0]  in_rs1_idx,
    input  logic [31:0] in_rs1_data,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        csr_enable,
    output csr_op_e     csr_op,
    output system_e     csr_name,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic [31:0] csr_pc,
    output logic        ecall,
    output logic        mret,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        ebreak,
    output logic        illegal
);

    sysu_state_e state, state_next;
    op_kind_e    kind_q;
    logic [2:0]  funct3_q;
    logic [11:0] imm12_q;
    logic [4:0]  rs1_idx_q;
    logic [31:0] rs1_data_q;
    logic [31:0] pc_q;
    csr_set_t    csr_req;

    logic dec_csr, dec_ecall, dec_mret, dec_ebreak, accept;

    always_comb begin
        dec_csr    = (in_funct3[1:0] != 2'b00);
        dec_ecall  = (in_funct3 == F3_PRIV) && (in_imm12 == F12_ECALL);
        dec_mret   = (in_funct3 == F3_PRIV) && (in_imm12 == F12_MRET);
        dec_ebreak = (in_funct3 == F3_PRIV) && (in_imm12 == F12_EBREAK);
    end

    // A flush in IDLE must also block a same-cycle accept.
    assign in_ready = (state == S_IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next     = state;
        csr_req        = '{csr_enable: 1'b0, csr_op: CSR_READ, csr_name: CSR_NONE};
        csr_wdata      = 32'd0;
        ecall          = 1'b0;
        mret           = 1'b0;
        out_valid      = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && (dec_csr || dec_ecall || dec_mret)) state_next = S_EXEC;
            end
            S_EXEC: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (kind_q == OP_CSR) begin
                    csr_req.csr_enable = 1'b1;
                    csr_req.csr_op     = csr_op_of(funct3_q[1:0], rs1_idx_q);
                    csr_req.csr_name   = system_e'(imm12_q);
                    csr_wdata          = funct3_q[2] ? {27'd0, rs1_idx_q} : rs1_data_q;
                    state_next         = S_WB;
                end else begin
                    csr_req.csr_name = (kind_q == OP_ECALL) ? system_e'(MTVEC_ADDR)
                                                            : system_e'(MEPC_ADDR);
                    state_next       = S_TRAP;
                end
            end
            S_TRAP: begin
                ecall      = (kind_q == OP_ECALL);
                mret       = (kind_q == OP_MRET);
                state_next = S_REDIR;
            end
            S_WB: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                if (redirect_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign csr_enable = csr_req.csr_enable;
    assign csr_op     = csr_req.csr_op;
    assign csr_name   = csr_req.csr_name;
    assign csr_pc     = pc_q;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            kind_q      <= OP_CSR;
            funct3_q    <= 3'd0;
            imm12_q     <= 12'd0;
            rs1_idx_q   <= 5'd0;
            rs1_data_q  <= 32'd0;
            pc_q        <= 32'd0;
            out_rd      <= 5'd0;
            out_data    <= 32'd0;
            redirect_pc <= 32'd0;
            ebreak      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state   <= state_next;
            ebreak  <= accept && dec_ebreak;
            illegal <= accept && !(dec_csr || dec_ecall || dec_mret || dec_ebreak);
            if (accept) begin
                kind_q     <= dec_ecall ? OP_ECALL : (dec_mret ? OP_MRET : OP_CSR);
                funct3_q   <= in_funct3;
                imm12_q    <= in_imm12;
                rs1_idx_q  <= in_rs1_idx;
                rs1_data_q <= in_rs1_data;
                pc_q       <= in_pc;
                out_rd     <= in_rd;
            end
            // Old CSR value or trap target is captured on the commit cycle only.
            if (state == S_EXEC && !flush) begin
                if (kind_q == OP_CSR) out_data    <= csr_rdata;
                else                  redirect_pc <= csr_rdata & TARGET_MASK;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_sysu.sv
// Scoreboard bench for the SYSTEM unit: a small CSR-file model answers the DUT, and a
// spec-level reference model predicts writebacks, pulses and redirects.
module tb_ysyx_24080006_sysu;
    import ysyx_24080006_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_ready;
    logic [2:0]  in_funct3;
    logic [11:0] in_imm12;
    logic [4:0]  in_rs1_idx, in_rd, out_rd;
    logic [31:0] in_rs1_data, in_pc;
    logic        flush;
    logic        csr_enable;
    csr_op_e     csr_op;
    system_e     csr_name;
    logic [31:0] csr_wdata, csr_rdata, csr_pc;
    logic        ecall, mret, out_valid, out_ready;
    logic [31:0] out_data, redirect_pc;
    logic        redirect_valid, redirect_ready, ebreak, illegal;

    ysyx_24080006_sysu dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3), .in_imm12(in_imm12),
        .in_rs1_idx(in_rs1_idx), .in_rs1_data(in_rs1_data), .in_rd(in_rd), .in_pc(in_pc),
        .flush(flush),
        .csr_enable(csr_enable), .csr_op(csr_op), .csr_name(csr_name), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_pc(csr_pc), .ecall(ecall), .mret(mret),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .ebreak(ebreak), .illegal(illegal)
    );

    initial forever #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // CSR indices: 0 mstatus, 1 mtvec, 2 mscratch, 3 mepc, 4 mcause
    function automatic int csr_idx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h340: return 2;
            12'h341: return 3;
            12'h342: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] csr_reset_val(input int i);
        return (i == 0) ? 32'h0000_1800 : 32'd0;
    endfunction

    // ---------------- CSR-file model (mtvec keeps its mode bits at zero) ----------------
    logic        csr_rst = 1'b1;
    logic [31:0] env_csr [5];
    int          env_sel;
    logic [31:0] env_next;

    always_comb begin
        env_sel   = csr_idx(csr_name);
        csr_rdata = (env_sel >= 0) ? env_csr[env_sel] : 32'd0;
        case (csr_op)
            CSR_WRITE: env_next = csr_wdata;
            CSR_SET:   env_next = csr_rdata | csr_wdata;
            CSR_CLEAR: env_next = csr_rdata & ~csr_wdata;
            default:   env_next = csr_rdata;
        endcase
        if (env_sel == 1) env_next = env_next & ~32'd3;
    end

    always @(posedge clock) begin
        if (csr_rst) begin
            for (int i = 0; i < 5; i++) env_csr[i] <= csr_reset_val(i);
        end else begin
            if (csr_enable && env_sel >= 0) env_csr[env_sel] <= env_next;
            if (ecall) begin
                env_csr[3] <= csr_pc;
                env_csr[4] <= 32'd11;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef enum {EV_WB, EV_REDIR, EV_ECALL, EV_MRET, EV_EBREAK, EV_ILLEGAL} ev_e;
    typedef struct {
        ev_e         kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_csr [5];

    task automatic push_exp(input ev_e k, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.rd   = r;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic ref_csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                              input logic [31:0] d, input logic [4:0] rd);
        int i;
        logic [31:0] old, src, nv;
        i   = csr_idx(a);
        old = (i >= 0) ? ref_csr[i] : 32'd0;
        src = f3[2] ? {27'd0, idx} : d;
        nv  = old;
        case (f3[1:0])
            2'b01: nv = src;
            2'b10: if (idx != 5'd0) nv = old | src;
            2'b11: if (idx != 5'd0) nv = old & ~src;
            default: ;
        endcase
        if (i == 1) nv = nv & ~32'd3;
        if (i >= 0) ref_csr[i] = nv;
        push_exp(EV_WB, rd, old);
    endtask

    // ---------------- ready generation ----------------
    bit rand_ready = 1'b0;
    bit force_out_ready = 1'b1;
    bit force_red_ready = 1'b1;

    initial begin
        out_ready      = 1'b1;
        redirect_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (rand_ready) begin
                out_ready      = ($urandom_range(0, 3) != 0);
                redirect_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready      = force_out_ready;
                redirect_ready = force_red_ready;
            end
        end
    end

    // ---------------- monitor ----------------
    bit          hold_out, hold_red;
    logic [31:0] held_data, held_pc;
    logic [4:0]  held_rd;

    task automatic take(input ev_e k);
        exp_t e;
        if (sb.size() == 0) begin
            fail_now($sformatf("unexpected_event_%s", k.name()));
        end else begin
            e = sb.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            case (k)
                EV_WB: begin
                    check("wb_rd", 32'(out_rd), 32'(e.rd));
                    check("wb_data", out_data, e.data);
                end
                EV_REDIR: check("redirect_pc", redirect_pc, e.data);
                EV_ECALL: check("ecall_csr_pc", csr_pc, e.data);
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(negedge clock);
        #3;
        if (reset) begin
            hold_out = 1'b0;
            hold_red = 1'b0;
        end else begin
            if (hold_out) begin
                check("wb_hold_valid", 32'(out_valid), 32'd1);
                check("wb_hold_data", out_data, held_data);
                check("wb_hold_rd", 32'(out_rd), 32'(held_rd));
            end
            if (hold_red) begin
                check("redir_hold_valid", 32'(redirect_valid), 32'd1);
                check("redir_hold_pc", redirect_pc, held_pc);
            end
            hold_out  = out_valid && !out_ready;
            hold_red  = redirect_valid && !redirect_ready;
            held_data = out_data;
            held_rd   = out_rd;
            held_pc   = redirect_pc;
            if (ecall || mret)
                check("pulse_exclusive", 32'((ecall && mret) || csr_enable), 32'd0);
            if (out_valid && out_ready)           take(EV_WB);
            if (redirect_valid && redirect_ready) take(EV_REDIR);
            if (ecall)                            take(EV_ECALL);
            if (mret)                             take(EV_MRET);
            if (ebreak)                           take(EV_EBREAK);
            if (illegal)                          take(EV_ILLEGAL);
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] f3, input logic [11:0] imm, input logic [4:0] idx,
                         input logic [31:0] d, input logic [4:0] rd, input logic [31:0] pc,
                         input bit do_flush, input bit late_flush);
        bit is_csr, is_ecall, is_mret, is_ebreak, goes_exec, flushing;
        csr_op_e exp_op;
        int n;
        is_csr    = (f3[1:0] != 2'b00);
        is_ecall  = (f3 == 3'b000) && (imm == 12'h000);
        is_mret   = (f3 == 3'b000) && (imm == 12'h302);
        is_ebreak = (f3 == 3'b000) && (imm == 12'h001);
        goes_exec = is_csr || is_ecall || is_mret;
        flushing  = do_flush && goes_exec;
        if (f3[1:0] == 2'b01)      exp_op = CSR_WRITE;
        else if (idx == 5'd0)      exp_op = CSR_READ;
        else if (f3[1:0] == 2'b10) exp_op = CSR_SET;
        else                       exp_op = CSR_CLEAR;

        @(negedge clock);
        in_valid = 1'b1; in_funct3 = f3; in_imm12 = imm; in_rs1_idx = idx;
        in_rs1_data = d; in_rd = rd; in_pc = pc;
        #1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        if (!flushing) begin
            if (is_csr) ref_csr_op(f3, imm, idx, d, rd);
            else if (is_ecall) begin
                push_exp(EV_ECALL, 5'd0, pc);
                push_exp(EV_REDIR, 5'd0, ref_csr[1] & 32'hFFFF_FFFE);
                ref_csr[3] = pc;
                ref_csr[4] = 32'd11;
            end else if (is_mret) begin
                push_exp(EV_MRET, 5'd0, 32'd0);
                push_exp(EV_REDIR, 5'd0, ref_csr[3] & 32'hFFFF_FFFE);
            end else if (is_ebreak) push_exp(EV_EBREAK, 5'd0, 32'd0);
            else                    push_exp(EV_ILLEGAL, 5'd0, 32'd0);
        end

        // cycle after accept: EXEC, or the ebreak/illegal pulse
        @(negedge clock);
        in_valid = 1'b0;
        flush    = flushing;
        #1;
        if (goes_exec) begin
            check("exec_csr_enable", 32'(csr_enable), 32'(is_csr && !flushing));
            if (is_csr && !flushing) begin
                check("exec_csr_op", 32'(csr_op), 32'(exp_op));
                check("exec_csr_name", 32'(csr_name), 32'(imm));
                check("exec_csr_wdata", csr_wdata, f3[2] ? {27'd0, idx} : d);
            end
            if (!is_csr && !flushing)
                check("exec_trap_name", 32'(csr_name), is_ecall ? 32'h305 : 32'h341);
        end else begin
            check(is_ebreak ? "ebreak_pulse" : "illegal_pulse",
                  32'(is_ebreak ? ebreak : illegal), 32'd1);
            check("pulse_no_strobe", 32'(csr_enable), 32'd0);
        end

        @(negedge clock);
        flush = late_flush && goes_exec && !flushing;
        #1;
        if (flushing)       check("flush_in_ready", 32'(in_ready), 32'd1);
        else if (is_csr)    check("wb_latency", 32'(out_valid), 32'd1);
        else if (is_ecall)  check("ecall_latency", 32'(ecall), 32'd1);
        else if (is_mret)   check("mret_latency", 32'(mret), 32'd1);
        else                check("pulse_one_cycle", 32'(ebreak || illegal), 32'd0);

        @(negedge clock);
        flush = 1'b0;
        #1;
        if ((is_ecall || is_mret) && !flushing)
            check("redirect_latency", 32'(redirect_valid), 32'd1);
        if (flushing) check("flush_no_wb", 32'(out_valid), 32'd0);

        n = 0;
        forever begin
            @(negedge clock);
            #4;
            if (sb.size() == 0 && in_ready) break;
            if (++n > 300) begin
                fail_now("completion_timeout");
                sb.delete();
                break;
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [2:0]  f3_tab [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    logic [11:0] addr_tab [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};

    initial begin
        int sel;
        logic [2:0]  r_f3;
        logic [11:0] r_imm;
        logic [4:0]  r_idx;

        in_valid = 1'b0; in_funct3 = 3'd0; in_imm12 = 12'd0; in_rs1_idx = 5'd0;
        in_rs1_data = 32'd0; in_rd = 5'd0; in_pc = 32'd0; flush = 1'b0;
        for (int i = 0; i < 5; i++) ref_csr[i] = csr_reset_val(i);
        repeat (3) @(negedge clock);
        reset   = 1'b0;
        csr_rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_csr_enable", 32'(csr_enable), 32'd0);
        check("rst_csr_name", 32'(csr_name), 32'd0);
        check("rst_pulses", {28'd0, ecall, mret, ebreak, illegal}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);

        // CSRRW mtvec, then read back through CSRRS x0
        issue(3'b001, 12'h305, 5'd5, 32'h8000_0101, 5'd10, 32'h3000_0000, 0, 0);
        issue(3'b010, 12'h305, 5'd0, 32'hDEAD_BEEF, 5'd11, 32'h3000_0004, 0, 0);
        // CSRRSI mstatus zimm=8, then read back
        issue(3'b110, 12'h300, 5'd8, 32'h0, 5'd12, 32'h3000_0008, 0, 0);
        issue(3'b010, 12'h300, 5'd0, 32'h0, 5'd13, 32'h3000_000C, 0, 0);
        // ecall with redirect held off for a few cycles, then mcause read
        issue(3'b001, 12'h305, 5'd6, 32'h3000_0400, 5'd0, 32'h3000_000C, 0, 0);
        force_red_ready = 1'b0;
        fork
            issue(3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h3000_0010, 0, 0);
            begin
                repeat (6) @(negedge clock);
                force_red_ready = 1'b1;
            end
        join
        issue(3'b010, 12'h342, 5'd0, 32'h0, 5'd14, 32'h3000_0400, 0, 0);
        // mret to mepc, including an odd mepc to exercise the target mask
        issue(3'b001, 12'h341, 5'd7, 32'h3000_0014, 5'd0, 32'h3000_0404, 0, 0);
        issue(3'b000, 12'h302, 5'd0, 32'h0, 5'd0, 32'h3000_0408, 0, 0);
        issue(3'b001, 12'h341, 5'd7, 32'h3000_0021, 5'd0, 32'h3000_0014, 0, 0);
        issue(3'b000, 12'h302, 5'd0, 32'h0, 5'd0, 32'h3000_0018, 0, 0);
        // flush during EXEC of CSRRW mtvec, then confirm mtvec is unchanged
        issue(3'b001, 12'h305, 5'd5, 32'h1234_5678, 5'd10, 32'h3000_0020, 1, 0);
        issue(3'b010, 12'h305, 5'd0, 32'h0, 5'd15, 32'h3000_0024, 0, 0);
        // illegal encodings and ebreak
        issue(3'b000, 12'h105, 5'd0, 32'h0, 5'd0, 32'h3000_0028, 0, 0);
        issue(3'b100, 12'h300, 5'd3, 32'h0, 5'd1, 32'h3000_002C, 0, 0);
        issue(3'b000, 12'h001, 5'd0, 32'h0, 5'd0, 32'h3000_0030, 0, 0);

        // flush in IDLE blocks a same-cycle accept
        @(negedge clock);
        in_valid = 1'b1; in_funct3 = 3'b000; in_imm12 = 12'h001; flush = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush_blocks_accept", 32'(ebreak), 32'd0);

        // reset while waiting in WB
        force_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        in_valid = 1'b1; in_funct3 = 3'b001; in_imm12 = 12'h340; in_rs1_idx = 5'd7;
        in_rs1_data = 32'hCAFE_F00D; in_rd = 5'd9;
        #1;
        check("rstwb_in_ready", 32'(in_ready), 32'd1);
        ref_csr_op(3'b001, 12'h340, 5'd7, 32'hCAFE_F00D, 5'd9);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("rstwb_exec_strobe", 32'(csr_enable), 32'd1);
        @(negedge clock);
        #1;
        check("rstwb_out_valid", 32'(out_valid), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("rstwb_out_valid_dropped", 32'(out_valid), 32'd0);
        sb.delete();
        reset = 1'b0;
        force_out_ready = 1'b1;
        @(negedge clock);
        #1;
        check("rstwb_in_ready_after", 32'(in_ready), 32'd1);
        issue(3'b010, 12'h340, 5'd0, 32'h0, 5'd16, 32'h3000_0034, 0, 0);

        // randomized phase with back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                r_f3  = f3_tab[$urandom_range(0, 5)];
                r_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                issue(r_f3, addr_tab[$urandom_range(0, 4)], r_idx, $urandom, 5'($urandom),
                      $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0);
            end else if (sel == 6 || sel == 7) begin
                issue(3'b000, (sel == 6) ? 12'h000 : 12'h302, 5'd0, 32'h0, 5'd0,
                      $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0);
            end else if (sel == 8) begin
                issue(3'b000, 12'h001, 5'd0, 32'h0, 5'd0, $urandom & 32'hFFFF_FFFC, 0, 0);
            end else begin
                if ($urandom_range(0, 1) == 0) begin
                    r_f3  = 3'b100;
                    r_imm = 12'($urandom);
                end else begin
                    r_f3 = 3'b000;
                    do r_imm = 12'($urandom);
                    while (r_imm == 12'h000 || r_imm == 12'h001 || r_imm == 12'h302);
                end
                issue(r_f3, r_imm, 5'($urandom), $urandom, 5'($urandom),
                      $urandom & 32'hFFFF_FFFC, 0, 0);
            end
        end
        rand_ready = 1'b0;
        repeat (3) @(negedge clock);
        #4;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 5; i++)
            check($sformatf("final_csr_%03h", addr_tab[i]), env_csr[i], ref_csr[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
